// File: rtl/axis_source.sv
// ----------------------------------------------------------------------------
// axis_source
//
// AXI-Stream master transmitter. Upstream beats are queued in a small FIFO,
// then presented one at a time from an output register on the T* pins. A
// programmable idle gap can be inserted after every handshake. Free-running
// beat and packet counters track completed transfers.
//
// Handshake semantics (both sides):
//   Upstream:   a beat is written when in_valid & in_ready. in_ready depends
//               only on registered FIFO occupancy, never on a same-cycle read.
//   Downstream: a transfer completes when TVALID & (TREADY | ~tready_en).
//               Once TVALID rises, TVALID and every T* field hold until that
//               transfer completes. With tready_en=0, TREADY is ignored.
//
// Ports:
//   ACLK, ARESETn      clock, asynchronous active-low reset
//   in_*               upstream beat fields, in_valid / in_ready handshake
//   tready_en          1 = sink drives TREADY, 0 = treat TREADY as 1
//   gap_cycles         idle cycles inserted after each handshake
//   stats_clr          synchronous clear of beat_count / pkt_count
//   T*                 AXI-Stream master interface
//   fifo_level         FIFO occupancy (output register not included)
//   beat_count         completed handshakes
//   pkt_count          completed handshakes with TLAST=1
//   dbg_state_o        current FSM state (0 IDLE, 1 SEND, 2 GAP)
// ----------------------------------------------------------------------------
module axis_source #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            ACLK,
  input  logic                            ARESETn,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic [DATA_WIDTH/8-1:0]         in_strb,
  input  logic [DATA_WIDTH/8-1:0]         in_keep,
  input  logic                            in_last,
  input  logic [ID_WIDTH-1:0]             in_id,
  input  logic [DEST_WIDTH-1:0]           in_dest,
  input  logic [USER_WIDTH-1:0]           in_user,
  input  logic                            tready_en,
  input  logic [7:0]                      gap_cycles,
  input  logic                            stats_clr,
  output logic                            TVALID,
  output logic [DATA_WIDTH-1:0]           TDATA,
  output logic [DATA_WIDTH/8-1:0]         TSTRB,
  output logic [DATA_WIDTH/8-1:0]         TKEEP,
  output logic                            TLAST,
  output logic [ID_WIDTH-1:0]             TID,
  output logic [DEST_WIDTH-1:0]           TDEST,
  output logic [USER_WIDTH-1:0]           TUSER,
  input  logic                            TREADY,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [31:0]                     beat_count,
  output logic [31:0]                     pkt_count,
  output logic [1:0]                      dbg_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = DATA_WIDTH / 8;

  // Packed beat layout, LSB first: data, strb, keep, last, id, dest, user.
  localparam int O_STRB = DATA_WIDTH;
  localparam int O_KEEP = O_STRB + SW;
  localparam int O_LAST = O_KEEP + SW;
  localparam int O_ID   = O_LAST + 1;
  localparam int O_DEST = O_ID + ID_WIDTH;
  localparam int O_USER = O_DEST + DEST_WIDTH;
  localparam int EW     = O_USER + USER_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      gap_q, gap_d;
  logic [EW-1:0]   out_q;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic [31:0]     beat_q, pkt_q;

  logic            fifo_empty;
  logic            wr_en;
  logic            load;
  logic            hs;
  logic [EW-1:0]   wr_entry;

  assign fifo_empty = (level_q == '0);
  assign in_ready   = (level_q < LW'(FIFO_DEPTH));
  assign wr_en      = in_valid & in_ready;
  assign wr_entry   = {in_user, in_dest, in_id, in_last, in_keep, in_strb, in_data};

  // TVALID is a decode of the registered state, so it carries no
  // combinational path from TREADY.
  assign TVALID = (state_q == ST_SEND);
  assign hs     = TVALID & (TREADY | ~tready_en);

  // Next-state logic. 'load' pops the FIFO head into the output register.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          load    = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (hs) begin
          if (gap_cycles != 8'd0) begin
            gap_d   = gap_cycles;
            state_d = ST_GAP;
          end else if (!fifo_empty) begin
            load    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        // The last gap cycle acts like IDLE so the next beat follows after
        // exactly gap_cycles low cycles.
        if (gap_q <= 8'd1) begin
          gap_d = 8'd0;
          if (!fifo_empty) begin
            load    = 1'b1;
            state_d = ST_SEND;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gap_d   = 8'd0;
      end
    endcase
  end

  assign level_d = level_q + {{(LW-1){1'b0}}, wr_en} - {{(LW-1){1'b0}}, load};

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q  <= ST_IDLE;
      gap_q    <= 8'd0;
      out_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      level_q <= level_d;
      if (load) begin
        out_q    <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge ACLK) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Counters: clear wins over a same-cycle increment.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      beat_q <= 32'd0;
      pkt_q  <= 32'd0;
    end else if (stats_clr) begin
      beat_q <= 32'd0;
      pkt_q  <= 32'd0;
    end else if (hs) begin
      beat_q <= beat_q + 32'd1;
      if (out_q[O_LAST]) begin
        pkt_q <= pkt_q + 32'd1;
      end
    end
  end

  assign TDATA       = out_q[0 +: DATA_WIDTH];
  assign TSTRB       = out_q[O_STRB +: SW];
  assign TKEEP       = out_q[O_KEEP +: SW];
  assign TLAST       = out_q[O_LAST];
  assign TID         = out_q[O_ID +: ID_WIDTH];
  assign TDEST       = out_q[O_DEST +: DEST_WIDTH];
  assign TUSER       = out_q[O_USER +: USER_WIDTH];
  assign fifo_level  = level_q;
  assign beat_count  = beat_q;
  assign pkt_count   = pkt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axis_source.sv
// ----------------------------------------------------------------------------
// tb_axis_source: directed testbench for axis_source with default parameters.
// Inputs are driven 1 ns after the rising edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_axis_source;

  logic        ACLK;
  logic        ARESETn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_strb;
  logic [3:0]  in_keep;
  logic        in_last;
  logic [3:0]  in_id;
  logic [3:0]  in_dest;
  logic [0:0]  in_user;
  logic        tready_en;
  logic [7:0]  gap_cycles;
  logic        stats_clr;
  logic        TVALID;
  logic [31:0] TDATA;
  logic [3:0]  TSTRB;
  logic [3:0]  TKEEP;
  logic        TLAST;
  logic [3:0]  TID;
  logic [3:0]  TDEST;
  logic [0:0]  TUSER;
  logic        TREADY;
  logic [3:0]  fifo_level;
  logic [31:0] beat_count;
  logic [31:0] pkt_count;
  logic [1:0]  dbg_state_o;

  int vectors     = 0;
  int miscompares = 0;

  axis_source dut (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_strb     (in_strb),
    .in_keep     (in_keep),
    .in_last     (in_last),
    .in_id       (in_id),
    .in_dest     (in_dest),
    .in_user     (in_user),
    .tready_en   (tready_en),
    .gap_cycles  (gap_cycles),
    .stats_clr   (stats_clr),
    .TVALID      (TVALID),
    .TDATA       (TDATA),
    .TSTRB       (TSTRB),
    .TKEEP       (TKEEP),
    .TLAST       (TLAST),
    .TID         (TID),
    .TDEST       (TDEST),
    .TUSER       (TUSER),
    .TREADY      (TREADY),
    .fifo_level  (fifo_level),
    .beat_count  (beat_count),
    .pkt_count   (pkt_count),
    .dbg_state_o (dbg_state_o)
  );

  // Clock and watchdog
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  // Driver helpers
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_beat(input logic [31:0] d, input logic l);
    in_data = d;
    in_strb = d[3:0];
    in_keep = 4'hF;
    in_last = l;
    in_id   = d[3:0];
    in_dest = d[7:4];
    in_user = d[0:0];
  endtask

  task automatic push(input logic [31:0] d, input logic l);
    set_beat(d, l);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [8:0] gap_pat;

  initial begin
    ARESETn    = 1'b0;
    in_valid   = 1'b0;
    set_beat(32'h0, 1'b0);
    tready_en  = 1'b1;
    gap_cycles = 8'd0;
    stats_clr  = 1'b0;
    TREADY     = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_tvalid",   {63'd0, TVALID},     64'd0);
    chk("rst_tdata",    {32'd0, TDATA},      64'd0);
    chk("rst_level",    {60'd0, fifo_level}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready},   64'd1);
    chk("rst_beats",    {32'd0, beat_count}, 64'd0);
    chk("rst_pkts",     {32'd0, pkt_count},  64'd0);
    chk("rst_state",    {62'd0, dbg_state_o}, 64'd0);
    ARESETn = 1'b1;
    tick();

    // Single beat: TVALID rises one cycle after the write, lasts one cycle
    push(32'hA5A5_A5A5, 1'b1);
    chk("single_tvalid_k", {63'd0, TVALID},     64'd0);
    chk("single_level_k",  {60'd0, fifo_level}, 64'd1);
    tick();
    chk("single_tvalid",   {63'd0, TVALID},     64'd1);
    chk("single_tdata",    {32'd0, TDATA},      64'hA5A5_A5A5);
    chk("single_tlast",    {63'd0, TLAST},      64'd1);
    chk("single_tid",      {60'd0, TID},        64'h5);
    chk("single_tdest",    {60'd0, TDEST},      64'hA);
    chk("single_tstrb",    {60'd0, TSTRB},      64'h5);
    chk("single_tkeep",    {60'd0, TKEEP},      64'hF);
    chk("single_tuser",    {63'd0, TUSER},      64'd1);
    tick();
    chk("single_tvalid_end", {63'd0, TVALID},     64'd0);
    chk("single_beats",      {32'd0, beat_count}, 64'd1);
    chk("single_pkts",       {32'd0, pkt_count},  64'd1);

    // Backpressure: 4 beats, TREADY low for 5 cycles
    TREADY = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h100 + i, (i == 3));
    chk("bp_level", {60'd0, fifo_level}, 64'd3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_tvalid", {63'd0, TVALID}, 64'd1);
      chk("bp_hold_tdata",  {32'd0, TDATA},  64'h100);
      tick();
    end
    TREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_rel_tvalid", {63'd0, TVALID}, 64'd1);
      chk("bp_rel_tdata",  {32'd0, TDATA},  64'h100 + 64'(i));
      tick();
    end
    chk("bp_drained", {63'd0, TVALID},     64'd0);
    chk("bp_beats",   {32'd0, beat_count}, 64'd5);
    chk("bp_pkts",    {32'd0, pkt_count},  64'd2);

    // Full FIFO: 9 beats with TREADY low, then release while a write is offered
    TREADY = 1'b0;
    for (int i = 0; i < 9; i++) push(32'h200 + i, (i == 8));
    chk("full_level",    {60'd0, fifo_level}, 64'd8);
    chk("full_in_ready", {63'd0, in_ready},   64'd0);
    set_beat(32'h2FF, 1'b0);
    in_valid = 1'b1;
    TREADY   = 1'b1;
    chk("full_no_ready_through", {63'd0, in_ready}, 64'd0);
    chk("full_head", {32'd0, TDATA}, 64'h200);
    tick();
    in_valid = 1'b0;
    chk("full_level_after_read", {60'd0, fifo_level}, 64'd7);
    for (int i = 1; i < 9; i++) begin
      chk("full_tvalid", {63'd0, TVALID}, 64'd1);
      chk("full_tdata",  {32'd0, TDATA},  64'h200 + 64'(i));
      tick();
    end
    chk("full_drained", {63'd0, TVALID},     64'd0);
    chk("full_empty",   {60'd0, fifo_level}, 64'd0);
    chk("full_beats",   {32'd0, beat_count}, 64'd14);
    chk("full_pkts",    {32'd0, pkt_count},  64'd3);

    // Gap throttling: G=3, TVALID pattern 1,0,0,0,1,0,0,0,1
    gap_cycles = 8'd3;
    TREADY     = 1'b0;
    for (int i = 0; i < 3; i++) push(32'h300 + i, (i == 2));
    TREADY  = 1'b1;
    gap_pat = 9'b1_0001_0001;
    for (int i = 0; i < 9; i++) begin
      chk("gap_pattern", {63'd0, TVALID}, {63'd0, gap_pat[8-i]});
      if (i == 0) chk("gap_tdata0", {32'd0, TDATA}, 64'h300);
      if (i == 4) chk("gap_tdata1", {32'd0, TDATA}, 64'h301);
      if (i == 8) chk("gap_tdata2", {32'd0, TDATA}, 64'h302);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      chk("gap_trailing_low", {63'd0, TVALID}, 64'd0);
      tick();
    end
    gap_cycles = 8'd0;
    chk("gap_beats", {32'd0, beat_count}, 64'd17);
    chk("gap_pkts",  {32'd0, pkt_count},  64'd4);

    // No-TREADY mode: 5-beat packet streams with TREADY held at X
    tready_en = 1'b0;
    TREADY    = 1'bx;
    for (int i = 0; i < 5; i++) begin
      set_beat(32'h400 + i, (i == 4));
      in_valid = 1'b1;
      tick();
      if (i >= 1) begin
        chk("nordy_tvalid", {63'd0, TVALID}, 64'd1);
        chk("nordy_tdata",  {32'd0, TDATA},  64'h400 + 64'(i - 1));
      end
    end
    in_valid = 1'b0;
    tick();
    chk("nordy_last_tvalid", {63'd0, TVALID}, 64'd1);
    chk("nordy_last_tdata",  {32'd0, TDATA},  64'h404);
    chk("nordy_last_tlast",  {63'd0, TLAST},  64'd1);
    tick();
    chk("nordy_end",   {63'd0, TVALID},     64'd0);
    chk("nordy_beats", {32'd0, beat_count}, 64'd22);
    chk("nordy_pkts",  {32'd0, pkt_count},  64'd5);
    tready_en = 1'b1;
    TREADY    = 1'b1;

    // Reset mid-transfer with 3 beats queued
    TREADY = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h500 + i, (i == 3));
    chk("mid_tvalid_pre", {63'd0, TVALID},     64'd1);
    chk("mid_level_pre",  {60'd0, fifo_level}, 64'd3);
    ARESETn = 1'b0;
    #1;
    chk("mid_rst_tvalid",   {63'd0, TVALID},     64'd0);
    chk("mid_rst_tdata",    {32'd0, TDATA},      64'd0);
    chk("mid_rst_tlast",    {63'd0, TLAST},      64'd0);
    chk("mid_rst_level",    {60'd0, fifo_level}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, in_ready},   64'd1);
    chk("mid_rst_beats",    {32'd0, beat_count}, 64'd0);
    chk("mid_rst_pkts",     {32'd0, pkt_count},  64'd0);
    #2;
    ARESETn = 1'b1;
    TREADY  = 1'b1;
    tick();
    tick();
    chk("mid_flushed", {63'd0, TVALID}, 64'd0);

    // stats_clr during a handshake wins over the increment
    push(32'h600, 1'b1);
    tick();
    tick();
    chk("clr_pre_beats", {32'd0, beat_count}, 64'd1);
    chk("clr_pre_pkts",  {32'd0, pkt_count},  64'd1);
    push(32'h601, 1'b1);
    tick();
    chk("clr_hs_tvalid", {63'd0, TVALID}, 64'd1);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    chk("clr_beats", {32'd0, beat_count}, 64'd0);
    chk("clr_pkts",  {32'd0, pkt_count},  64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_source.md
# axis_source

Synthesizable AXI-Stream transmitter that drives the stream bus that the monitor BFM observes. It accepts beats from an upstream producer through a small FIFO and presents them on the AXI-Stream master pins with full VALID/READY compliance. A programmable inter-beat gap throttles the output. Free-running beat and packet counters are provided for scoreboarding. The block sits between DUT-side producers or test stimulus and any AXI-Stream sink, including designs where TREADY is not implemented.

## Interface
Parameters:
- DATA_WIDTH, 32: TDATA width in bits; must be a multiple of 8.
- ID_WIDTH, 4: TID width.
- DEST_WIDTH, 4: TDEST width.
- USER_WIDTH, 1: TUSER width.
- FIFO_DEPTH, 8: input FIFO entries; power of 2, ≥2.

Ports:
- ACLK  in  1  sole clock; all logic on the rising edge.
- ARESETn  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  FIFO not full.
- in_data / in_strb / in_keep / in_last / in_id / in_dest / in_user  in  DATA_WIDTH / DATA_WIDTH/8 / DATA_WIDTH/8 / 1 / ID_WIDTH / DEST_WIDTH / USER_WIDTH  upstream beat fields.
- tready_en  in  1  1 = sink implements TREADY; 0 = TREADY is ignored and treated as 1. Quasi-static: changes only while TVALID=0.
- gap_cycles  in  8  number of idle cycles inserted after each handshake.
- stats_clr  in  1  synchronous clear of the counters.
- TVALID, TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER  out  per parameters  AXI-Stream master outputs.
- TREADY  in  1  AXI-Stream sink ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy. The output register is not counted.
- beat_count  out  32  number of completed handshakes; wraps.
- pkt_count  out  32  number of completed handshakes with TLAST=1; wraps.

## Operation
- FIFO write occurs when in_valid and in_ready are both 1. in_ready = (fifo_level < FIFO_DEPTH).
- Handshake condition: hs = TVALID & (TREADY | ~tready_en).
- Output register holds the presented beat. It loads from the FIFO head.
- State machine:
  - IDLE (TVALID=0): when the FIFO is non-empty, load the output register and go to SEND.
  - SEND (TVALID=1): on hs:
    - if gap_cycles ≠ 0, load gap_cnt = gap_cycles and go to GAP;
    - else if the FIFO is non-empty, load the next beat and stay in SEND (back-to-back);
    - else go to IDLE.
  - GAP (TVALID=0): decrement gap_cnt each cycle. At gap_cnt == 1, behave as IDLE on the next edge.
- While TVALID=1 and hs=0, TVALID and all T* fields hold stable. They never change or drop before the handshake.
- FIFO read and FIFO write in the same cycle are both performed. fifo_level is unchanged.
- Counters:
  - beat_count increments on hs.
  - pkt_count increments on hs & TLAST.
  - Both wrap from 2^32−1 to 0.
  - stats_clr takes priority over a same-cycle increment; the counters read 0 on the next cycle.
- gap_cycles is sampled only at the handshake edge.

## Timing
- Reset values:
  - TVALID=0 and all T* data fields = 0.
  - fifo_level=0, beat_count=0, pkt_count=0, state IDLE, gap_cnt=0.
  - in_ready=1, because it is derived from fifo_level.
- Assertion of ARESETn mid-transfer immediately drops TVALID and flushes the FIFO. The in-flight beat is lost and not counted.
- Latency: a beat written into an empty FIFO at edge k, while in IDLE, gives TVALID=1 after edge k+1.
- Throughput:
  - With gap_cycles=0, TREADY=1 and the FIFO kept fed, one beat per cycle.
  - With gap_cycles=G, TVALID is low for exactly G cycles between beats.
- Full boundary: with fifo_level=FIFO_DEPTH, in_ready=0 even if a read happens in the same cycle. There is no combinational ready-through.
- Empty boundary: after the last beat handshakes with gap_cycles=0, TVALID=0 on the next cycle.
- With tready_en=0, the value of TREADY, including X, has no effect.

## Test plan
- Single beat: write TDATA=0xA5A5A5A5, TLAST=1 into an idle block with TREADY=1 → TVALID high for one cycle starting 1 cycle after the write; beat_count=1, pkt_count=1.
- Backpressure: queue 4 beats and hold TREADY=0 for 5 cycles → TVALID stays high and TDATA stays stable on beat 0; after TREADY rises, beats 0–3 appear on 4 consecutive cycles in order.
- Full FIFO: with TREADY=0, write FIFO_DEPTH+1 beats (9 with the default) → the first loads the output register, the next 8 fill the FIFO, fifo_level=8, in_ready=0; no beat is dropped or duplicated after release.
- Gap throttling: gap_cycles=3, 3 beats queued, TREADY=1 → TVALID pattern 1,0,0,0,1,0,0,0,1.
- No-TREADY mode: tready_en=0, TREADY=0 (or X), 5-beat packet → 5 consecutive transfers; pkt_count increments by 1.
- Reset and clear: assert ARESETn low while TVALID=1 with 3 beats queued → all outputs at their reset values; release, then pulse stats_clr during a handshake → counters read 0.
